// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART receive path
// Contents: rx_state_t FSM encoding, PAR_NONE/PAR_EVEN/PAR_ODD mode codes, clog2()
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop line synchroniser and 3-sample majority voter
// Ports:
//   clk, arst_n   clock, asynchronous active-low reset
//   rx            raw asynchronous serial line (idle high)
//   baud_tick     oversample strobe
//   tick_cnt      current oversample position inside the bit
//   rxs           synchronised line
//   maj_bit       2-of-3 vote of samples at OVS/2-1, OVS/2 and the live rxs;
//                 meaningful when baud_tick is high with tick_cnt == OVS/2+1
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int OVS = 16,
    parameter int CW  = clog2(OVS)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          rx,
    input  logic          baud_tick,
    input  logic [CW-1:0] tick_cnt,
    output logic          rxs,
    output logic          maj_bit
);

    localparam logic [CW-1:0] T_S0 = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] T_S1 = CW'(OVS / 2);

    logic meta_q;
    logic sync_q;
    logic s0_q;
    logic s1_q;

    // Flops reset to 1 so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            s0_q   <= 1'b1;
            s1_q   <= 1'b1;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            if (baud_tick && tick_cnt == T_S0) s0_q <= sync_q;
            if (baud_tick && tick_cnt == T_S1) s1_q <= sync_q;
        end
    end

    // Third sample is the live value at the decision tick, saving a flop.
    assign rxs     = sync_q;
    assign maj_bit = (s0_q & s1_q) | (s0_q & sync_q) | (s1_q & sync_q);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - parametrised UART receive engine (start detect, majority vote, deserialise, stop/parity check)
// Optional feature macro: UART_RX_PARITY_EN (adds PARITY state, honours parity_mode, drives parity_err)
// Ports:
//   clk, arst_n   clock, asynchronous active-low reset
//   rx_en         receiver enable, low aborts any frame
//   baud_tick     1-clk strobe, OVS per bit period
//   rx            raw serial line
//   parity_mode   00/11 none, 01 even, 10 odd
//   rx_data       last received word
//   rx_valid      1-clk pulse qualifying rx_data and error flags
//   busy          high from start detect until back in IDLE
//   frame_err     stop bit sampled 0 (valid with rx_valid)
//   parity_err    parity mismatch (valid with rx_valid)
//   break_det     line held low after a framing error
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int OVS       = 16,
    parameter int STOP_BITS = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              rx_en,
    input  logic              baud_tick,
    input  logic              rx,
    input  logic [1:0]        parity_mode,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              parity_err,
    output logic              break_det
);

    localparam int CW = clog2(OVS);
    localparam int BW = clog2(DATA_W);

    localparam logic [CW-1:0] T_DEC  = CW'(OVS / 2 + 1);
    localparam logic [CW-1:0] T_LAST = CW'(OVS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

    rx_state_t         state;
    logic [CW-1:0]     tick_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              stop0_ok;
    logic              rxs;
    logic              maj;
    logic              dec;
    logic              end_bit;
    logic              last_stop;
    logic              stop_ok;
    logic              par_flag;

    uart_rx_sync #(.OVS(OVS), .CW(CW)) u_sync (
        .clk       (clk),
        .arst_n    (arst_n),
        .rx        (rx),
        .baud_tick (baud_tick),
        .tick_cnt  (tick_cnt),
        .rxs       (rxs),
        .maj_bit   (maj)
    );

    assign dec     = baud_tick && (tick_cnt == T_DEC);
    assign end_bit = baud_tick && (tick_cnt == T_LAST);

    // In STOP, bit_cnt counts stop bits; the final one is the only one reported.
    assign last_stop = (STOP_BITS == 1) || (bit_cnt != '0);
    assign stop_ok   = maj && ((STOP_BITS == 1) || stop0_ok);

`ifdef UART_RX_PARITY_EN
    logic par_l;
    assign par_flag = par_l;
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
    assign par_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            stop0_ok   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_l      <= 1'b0;
`endif
        end else begin
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (!rx_en) begin
                state     <= ST_IDLE;
                tick_cnt  <= '0;
                bit_cnt   <= '0;
                busy      <= 1'b0;
                break_det <= 1'b0;
            end else begin
                // Bit-timing counter runs only while inside a frame; entry points clear it.
                if (state != ST_IDLE && state != ST_WAIT_HIGH && baud_tick)
                    tick_cnt <= end_bit ? '0 : tick_cnt + 1'b1;

                case (state)
                    ST_IDLE: begin
                        tick_cnt <= '0;
                        if (!rxs) begin
                            state   <= ST_START;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                    ST_START: begin
                        if (dec && maj) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            tick_cnt <= '0;
                        end else if (end_bit) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (dec) begin
                            if (LSB_FIRST != 0) shreg <= {maj, shreg[DATA_W-1:1]};
                            else                shreg <= {shreg[DATA_W-2:0], maj};
                        end
                        if (end_bit) begin
                            if (bit_cnt == B_LAST) begin
                                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                state   <= ST_PARITY;
`else
                                state   <= ST_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (dec) begin
                            case (parity_mode)
                                PAR_EVEN: par_l <= (maj != (^shreg));
                                PAR_ODD:  par_l <= (maj != (~^shreg));
                                default:  par_l <= 1'b0;
                            endcase
                        end
                        if (end_bit) state <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        if (dec) begin
                            if (last_stop) begin
                                // Reported half a bit early so the next start edge can be caught.
                                rx_data    <= shreg;
                                rx_valid   <= 1'b1;
                                frame_err  <= !stop_ok;
                                parity_err <= par_flag;
                                tick_cnt   <= '0;
                                bit_cnt    <= '0;
                                if (!stop_ok && !rxs) begin
                                    state     <= ST_WAIT_HIGH;
                                    break_det <= 1'b1;
                                end else begin
                                    state <= ST_IDLE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                stop0_ok <= maj;
                            end
                        end else if (end_bit) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_HIGH: begin
                        tick_cnt <= '0;
                        if (rxs) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            break_det <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        break_det <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core (8N1 LSB-first and 7-bit 2-stop MSB-first)
module tb_uart_rx_core;

    localparam int BIT_CLKS = 32;  // OVS=16, baud_tick every second clock

    logic       clk;
    logic       arst_n;
    logic       rx_en;
    logic       baud_tick;
    logic       rx;
    logic       rx2;
    logic [1:0] parity_mode;

    logic [7:0] rx_data;
    logic       rx_valid, busy, frame_err, parity_err, break_det;
    logic [6:0] d2_data;
    logic       d2_valid, d2_busy, d2_fe, d2_pe, d2_brk;

    int checks = 0;
    int errors = 0;

    int         vcnt = 0;
    logic [7:0] cap_data = '0;
    logic       cap_fe = 1'b0;
    logic       cap_pe = 1'b0;
    bit         busy_seen = 1'b0;
    int         v2cnt = 0;
    logic [6:0] cap2_data = '0;
    logic       cap2_fe = 1'b0;

    int v0;

    uart_rx_core #(.DATA_W(8), .OVS(16), .STOP_BITS(1), .LSB_FIRST(1)) dut (
        .clk(clk), .arst_n(arst_n), .rx_en(rx_en), .baud_tick(baud_tick), .rx(rx),
        .parity_mode(parity_mode), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .frame_err(frame_err), .parity_err(parity_err), .break_det(break_det)
    );

    uart_rx_core #(.DATA_W(7), .OVS(16), .STOP_BITS(2), .LSB_FIRST(0)) dut2 (
        .clk(clk), .arst_n(arst_n), .rx_en(rx_en), .baud_tick(baud_tick), .rx(rx2),
        .parity_mode(2'b00), .rx_data(d2_data), .rx_valid(d2_valid), .busy(d2_busy),
        .frame_err(d2_fe), .parity_err(d2_pe), .break_det(d2_brk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1 baud_tick = ~baud_tick;
        end
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt     = vcnt + 1;
            cap_data = rx_data;
            cap_fe   = frame_err;
            cap_pe   = parity_err;
        end
        if (busy) busy_seen = 1'b1;
        if (d2_valid) begin
            v2cnt     = v2cnt + 1;
            cap2_data = d2_data;
            cap2_fe   = d2_fe;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v, input bit to2);
        if (to2) rx2 = v;
        else     rx  = v;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_data(input logic [8:0] d, input int n, input bit msb, input bit to2);
        for (int i = 0; i < n; i++) bit_time(msb ? d[n-1-i] : d[i], to2);
    endtask

    // Start, 8 data bits LSB first, optional parity bit, one stop bit of value stop_v.
    task automatic send_frame(input logic [7:0] d, input logic par_v, input logic stop_v);
        bit_time(1'b0, 1'b0);
        send_data({1'b0, d}, 8, 1'b0, 1'b0);
`ifdef UART_RX_PARITY_EN
        bit_time(par_v, 1'b0);
`else
        if (par_v === 1'bx) $display("unexpected parity argument");
`endif
        bit_time(stop_v, 1'b0);
    endtask

    initial begin
        arst_n      = 1'b0;
        rx_en       = 1'b1;
        rx          = 1'b1;
        rx2         = 1'b1;
        parity_mode = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",   32'(rx_data),    32'h0);
        check("rst_valid",  32'(rx_valid),   32'h0);
        check("rst_busy",   32'(busy),       32'h0);
        check("rst_ferr",   32'(frame_err),  32'h0);
        check("rst_perr",   32'(parity_err), 32'h0);
        check("rst_brk",    32'(break_det),  32'h0);
        arst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 1: 0xA5 8N1
        v0 = vcnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        check("t1_count", 32'(vcnt),     32'(v0 + 1));
        check("t1_data",  32'(cap_data), 32'hA5);
        check("t1_ferr",  32'(cap_fe),   32'h0);
        check("t1_perr",  32'(cap_pe),   32'h0);
        check("t1_busy",  32'(busy),     32'h0);

        // 2: short low glitch is a false start
        v0 = vcnt;
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (10) @(posedge clk);
        #1 rx = 1'b1;
        repeat (64) @(posedge clk);
        #1;
        check("t2_busy_seen", 32'(busy_seen), 32'h1);
        check("t2_count",     32'(vcnt),      32'(v0));
        check("t2_busy",      32'(busy),      32'h0);

        // 3: framing error, line held low, then recovery
        v0 = vcnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3 * BIT_CLKS) @(posedge clk);
        #1;
        check("t3_count", 32'(vcnt),      32'(v0 + 1));
        check("t3_data",  32'(cap_data),  32'h3C);
        check("t3_ferr",  32'(cap_fe),    32'h1);
        check("t3_brk",   32'(break_det), 32'h1);
        check("t3_busy",  32'(busy),      32'h1);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t3_brk_clr",  32'(break_det), 32'h0);
        check("t3_busy_clr", 32'(busy),      32'h0);
        send_frame(8'h55, 1'b0, 1'b1);
        check("t3_count2", 32'(vcnt),     32'(v0 + 2));
        check("t3_data2",  32'(cap_data), 32'h55);
        check("t3_ferr2",  32'(cap_fe),   32'h0);

        // 4: parity
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1);
        check("t4_perr_bad",  32'(cap_pe),   32'h1);
        check("t4_data",      32'(cap_data), 32'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        check("t4_perr_good", 32'(cap_pe),   32'h0);
`else
        send_frame(8'h07, 1'b0, 1'b1);
        check("t4_perr_off",  32'(cap_pe),   32'h0);
        check("t4_data",      32'(cap_data), 32'h07);
`endif

        // 5: 7 bits, MSB first, two stop bits on the second instance
        bit_time(1'b0, 1'b1);
        send_data(9'h05A, 7, 1'b1, 1'b1);
        bit_time(1'b1, 1'b1);
        check("t5_no_early", 32'(v2cnt), 32'h0);
        bit_time(1'b1, 1'b1);
        check("t5_count", 32'(v2cnt),     32'h1);
        check("t5_data",  32'(cap2_data), 32'h5A);
        check("t5_ferr",  32'(cap2_fe),   32'h0);

        // 6a: rx_en dropped mid-DATA
        v0 = vcnt;
        bit_time(1'b0, 1'b0);
        send_data(9'h000, 3, 1'b0, 1'b0);
        rx_en = 1'b0;
        rx    = 1'b1;
        @(posedge clk);
        #1;
        check("t6_en_busy",  32'(busy),     32'h0);
        check("t6_en_valid", 32'(rx_valid), 32'h0);
        repeat (3) @(posedge clk);
        #1 rx_en = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1;
        check("t6_en_count", 32'(vcnt),    32'(v0));
        check("t6_en_data",  32'(rx_data), 32'h07);

        // 6b: reset during the stop bit
        bit_time(1'b0, 1'b0);
        send_data(9'h081, 8, 1'b0, 1'b0);
`ifdef UART_RX_PARITY_EN
        bit_time(1'b0, 1'b0);
`endif
        rx = 1'b1;
        repeat (10) @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        check("t6_rst_busy",  32'(busy),      32'h0);
        check("t6_rst_data",  32'(rx_data),   32'h0);
        check("t6_rst_valid", 32'(rx_valid),  32'h0);
        check("t6_rst_brk",   32'(break_det), 32'h0);
        check("t6_rst_data2", 32'(d2_data),   32'h0);
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clk);
        #1;
        check("t6_rst_count", 32'(vcnt),    32'(v0));
        check("t6_rst_hold",  32'(rx_data), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
